// File: rtl/ann_pkg.sv
// Shared types and constants for the neuron layer scheduler.
package ann_pkg;

    localparam int FP_W = 32;

    localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;
    localparam logic [FP_W-1:0] FP_ONE  = 32'h3F80_0000;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        DRAIN,
        OUT
    } sched_state_t;

    // Weight ROM footprint; bias words sit directly after the weights.
    function automatic int rom_words(input int n_in, input int n_neuron, input bit bias_en);
        return n_in * n_neuron + (bias_en ? n_neuron : 0);
    endfunction

endpackage

// File: rtl/x_vec_buf.sv
// Input vector register file: synchronous write, combinational read, cleared on reset.
module x_vec_buf
    import ann_pkg::*;
#(
    parameter int N_IN = 2,
    parameter int IW   = 1
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [IW-1:0]   waddr,
    input  logic [FP_W-1:0] wdata,
    input  logic [IW-1:0]   raddr,
    output logic [FP_W-1:0] rdata
);

    logic [FP_W-1:0] mem [N_IN];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_IN; i++) begin
                mem[i] <= FP_ZERO;
            end
        end else if (we && (32'(waddr) < N_IN)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = (32'(raddr) < N_IN) ? mem[raddr] : FP_ZERO;

endmodule

// File: rtl/neuron_layer_sched.sv
// Time-multiplexes one shared MAC/bias/sigmoid datapath across the neurons of a layer.
// Build option NEURON_SCHED_BIAS_EN issues the bias word as an extra MAC pair per neuron.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | capturing N_IN input words into the vector buffer
// ISSUE | stepping ROM addresses for neuron n, one operand pair per cycle
// DRAIN | waiting PIPE_LAT cycles for the datapath to produce the activation
// OUT   | holding the activation until the downstream accepts it
module neuron_layer_sched
    import ann_pkg::*;
#(
    parameter int N_IN     = 2,
    parameter int N_NEURON = 2,
    parameter int PIPE_LAT = 2,
    parameter int AW       = 8
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            x_valid,
    input  logic [FP_W-1:0] x_in,
    output logic            x_ready,
    output logic [AW-1:0]   w_addr,
    input  logic [FP_W-1:0] w_data,
    output logic [FP_W-1:0] mac_w,
    output logic [FP_W-1:0] mac_x,
    output logic            mac_en,
    output logic            mac_clr,
    input  logic [FP_W-1:0] act_in,
    output logic            y_valid,
    output logic [FP_W-1:0] y_data,
    output logic [7:0]      y_idx,
    input  logic            y_ready,
    output logic            busy,
    output logic            done
);

`ifdef NEURON_SCHED_BIAS_EN
    localparam bit BIAS_EN = 1'b1;
`else
    localparam bit BIAS_EN = 1'b0;
`endif

    localparam int N_PAIR    = N_IN + (BIAS_EN ? 1 : 0);
    localparam int ROM_WORDS = rom_words(N_IN, N_NEURON, BIAS_EN);
    localparam int KW        = $clog2(N_PAIR + 1);
    localparam int IW        = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int CW        = $clog2(PIPE_LAT + 1);

    if (N_IN < 1 || N_NEURON < 1 || PIPE_LAT < 1) begin : g_bad_param
        $error("neuron_layer_sched: N_IN, N_NEURON and PIPE_LAT must all be >= 1");
    end
    if (ROM_WORDS > (2 ** AW)) begin : g_bad_aw
        $error("neuron_layer_sched: weight ROM does not fit in 2**AW words");
    end
    if (N_NEURON > 256) begin : g_bad_idx
        $error("neuron_layer_sched: y_idx is 8 bits, N_NEURON must be <= 256");
    end

    sched_state_t    state, state_nx;
    logic [KW-1:0]   k;
    logic [7:0]      n;
    logic [CW-1:0]   drain_cnt;
    logic            pair_vld;
    logic [KW-1:0]   pair_k;
    logic            y_valid_q;
    logic [FP_W-1:0] y_data_q;
    logic [7:0]      y_idx_q;
    logic            done_q;
    logic [FP_W-1:0] x_rdata;
    logic [AW-1:0]   w_addr_c;
    logic            last_k;
    logic            last_load;
    logic            last_n;
    logic            bias_pair;

    assign last_load = (32'(k) == N_IN - 1);
    assign last_k    = (32'(k) == N_PAIR - 1);
    assign last_n    = (32'(n) == N_NEURON - 1);
    assign bias_pair = BIAS_EN && (32'(pair_k) == N_IN);

    x_vec_buf #(
        .N_IN (N_IN),
        .IW   (IW)
    ) u_x_buf (
        .clk   (clk),
        .rst   (rst),
        .we    ((state == LOAD) && x_valid),
        .waddr (IW'(k)),
        .wdata (x_in),
        .raddr (IW'(pair_k)),
        .rdata (x_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start)                   state_nx = LOAD;
            LOAD:    if (x_valid && last_load)    state_nx = ISSUE;
            ISSUE:   if (last_k)                  state_nx = DRAIN;
            DRAIN:   if (drain_cnt == '0)         state_nx = OUT;
            OUT:     if (y_ready)                 state_nx = last_n ? IDLE : ISSUE;
            default:                              state_nx = IDLE;
        endcase
    end

    // Counters, operand pipeline flag and the result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            k         <= '0;
            n         <= '0;
            drain_cnt <= '0;
            pair_vld  <= 1'b0;
            pair_k    <= '0;
            y_valid_q <= 1'b0;
            y_data_q  <= FP_ZERO;
            y_idx_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            pair_vld <= 1'b0;
            done_q   <= 1'b0;
            unique case (state)
                IDLE: begin
                    k <= '0;
                    n <= '0;
                end
                LOAD: begin
                    if (x_valid) begin
                        k <= last_load ? '0 : k + 1'b1;
                    end
                end
                ISSUE: begin
                    pair_vld  <= 1'b1;
                    pair_k    <= k;
                    k         <= k + 1'b1;
                    drain_cnt <= CW'(PIPE_LAT);
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        y_valid_q <= 1'b1;
                        y_data_q  <= act_in;
                        y_idx_q   <= n;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                OUT: begin
                    if (y_ready) begin
                        y_valid_q <= 1'b0;
                        k         <= '0;
                        if (last_n) begin
                            n      <= '0;
                            done_q <= 1'b1;
                        end else begin
                            n <= n + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // The bias word follows all weights, so it is addressed per neuron past the weight block.
    always_comb begin
        w_addr_c = '0;
        if (state == ISSUE) begin
            if (BIAS_EN && (32'(k) == N_IN)) begin
                w_addr_c = AW'(N_IN * N_NEURON + 32'(n));
            end else begin
                w_addr_c = AW'(32'(n) * N_IN + 32'(k));
            end
        end
    end

    assign w_addr  = w_addr_c;
    assign x_ready = (state == LOAD);
    assign busy    = (state != IDLE);
    assign mac_en  = pair_vld;
    assign mac_clr = pair_vld && (pair_k == '0);
    assign mac_w   = pair_vld ? w_data : FP_ZERO;
    assign mac_x   = pair_vld ? (bias_pair ? FP_ONE : x_rdata) : FP_ZERO;
    assign y_valid = y_valid_q;
    assign y_data  = y_data_q;
    assign y_idx   = y_idx_q;
    assign done    = done_q;

endmodule

// File: tb/tb_neuron_layer_sched.sv
// Scoreboard bench for neuron_layer_sched with a ROM and an integer stand-in for the shared datapath.
module tb_neuron_layer_sched;

    localparam int N_IN = 2;
    localparam int NN   = 3;
    localparam int PL   = 2;
    localparam int AW   = 8;
`ifdef NEURON_SCHED_BIAS_EN
    localparam int NPAIR = N_IN + 1;
`else
    localparam int NPAIR = N_IN;
`endif
    localparam int LAT     = NPAIR + 1 + PL;
    localparam int SPACING = NPAIR + 2 + PL;
    localparam logic [31:0] ONE = 32'h3F80_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          x_valid;
    logic [31:0]   x_in;
    logic          x_ready;
    logic [AW-1:0] w_addr;
    logic [31:0]   w_data;
    logic [31:0]   mac_w;
    logic [31:0]   mac_x;
    logic          mac_en;
    logic          mac_clr;
    logic [31:0]   act_in;
    logic          y_valid;
    logic [31:0]   y_data;
    logic [7:0]    y_idx;
    logic          y_ready;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    neuron_layer_sched #(
        .N_IN     (N_IN),
        .N_NEURON (NN),
        .PIPE_LAT (PL),
        .AW       (AW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .x_valid (x_valid),
        .x_in    (x_in),
        .x_ready (x_ready),
        .w_addr  (w_addr),
        .w_data  (w_data),
        .mac_w   (mac_w),
        .mac_x   (mac_x),
        .mac_en  (mac_en),
        .mac_clr (mac_clr),
        .act_in  (act_in),
        .y_valid (y_valid),
        .y_data  (y_data),
        .y_idx   (y_idx),
        .y_ready (y_ready),
        .busy    (busy),
        .done    (done)
    );

    typedef struct {
        logic [7:0]  idx;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rom [0:255];
    logic [31:0] x_vec [N_IN];
    logic [31:0] acc;
    logic [31:0] act_d;
    int          n_chk = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          cnt_en = 0;
    int          cnt_clr = 0;
    int          n_done = 0;
    int          last_acc = 0;
    int          issue_cyc = 0;
    int          pk = 0;
    logic        prev_xr = 1'b0;
    logic        prev_yv = 1'b0;
    logic        stall_win;
    logic        chk_spacing;
    logic [31:0] hold_data;
    logic [7:0]  hold_idx;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] swap16(input logic [31:0] v);
        return {v[15:0], v[31:16]};
    endfunction

    // Expected activation from the stimulus alone: the same fold the datapath model applies.
    function automatic logic [31:0] exp_act(input int n);
        logic [31:0] a;
        a = 32'h0;
        for (int k = 0; k < N_IN; k++) begin
            a = a * 32'd31 + (rom[n * N_IN + k] ^ swap16(x_vec[k]));
        end
`ifdef NEURON_SCHED_BIAS_EN
        a = a * 32'd31 + (rom[N_IN * NN + n] ^ swap16(ONE));
`endif
        return a;
    endfunction

    // Weight ROM with one-cycle read, and a datapath whose result appears PIPE_LAT cycles after the last pair.
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        w_data <= rom[w_addr];
        if (mac_en) acc <= (mac_clr ? 32'h0 : acc * 32'd31) + (mac_w ^ swap16(mac_x));
        act_d  <= acc;
    end
    assign act_in = act_d;

    always @(negedge clk) begin
        if (!rst) begin
            if (mac_en) begin
                cnt_en++;
                if (mac_clr) cnt_clr++;
                pk = mac_clr ? 0 : pk + 1;
`ifdef NEURON_SCHED_BIAS_EN
                if (pk == N_IN) chk("bias_x", mac_x, ONE);
`endif
            end
            if (busy && !x_ready && prev_xr) issue_cyc = cyc;
            if (chk_spacing && y_valid && !prev_yv && y_idx == 8'd0) chk("lat0", cyc - issue_cyc, LAT);
            if (stall_win) begin
                chk("stall_en", mac_en, 1'b0);
                chk("stall_data", y_data, hold_data);
                chk("stall_idx", y_idx, hold_idx);
            end
            if (y_valid && y_ready) begin
                chk("sb_nonempty", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("y_idx", y_idx, e.idx);
                    chk("y_data", y_data, e.data);
                end
                if (chk_spacing && y_idx != 8'd0) chk("y_spacing", cyc - last_acc, SPACING);
                last_acc = cyc;
            end
            if (done) begin
                n_done++;
                chk("done_lag", cyc, last_acc + 1);
            end
            prev_xr = x_ready;
            prev_yv = y_valid;
        end
    end

    task automatic push_all();
        for (int n = 0; n < NN; n++) begin
            exp_t e;
            e.idx  = 8'(n);
            e.data = exp_act(n);
            exp_q.push_back(e);
        end
    endtask

    task automatic start_pass();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic load_x();
        for (int k = 0; k < N_IN; k++) begin
            int t;
            x_valid = 1'b1;
            x_in    = x_vec[k];
            t = 0;
            while (!x_ready && t < 20) begin
                @(posedge clk); #1;
                t++;
            end
            chk("load_rdy", x_ready, 1'b1);
            @(posedge clk); #1;
        end
        x_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int prev;
        int t;
        prev = n_done;
        t = 0;
        while (n_done == prev && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        chk("done_seen", n_done, prev + 1);
    endtask

    task automatic wait_accepts(input int cnt, input int budget);
        int base;
        int t;
        base = last_acc;
        t = 0;
        for (int i = 0; i < cnt; i++) begin
            base = last_acc;
            while (last_acc == base && t < budget) begin
                @(posedge clk); #1;
                t++;
            end
        end
        chk("accept_to", t < budget, 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        int done_before;
        rst = 1'b1; start = 1'b0; x_valid = 1'b0; x_in = '0; y_ready = 1'b0;
        stall_win = 1'b0; chk_spacing = 1'b0; hold_data = '0; hold_idx = '0;
        acc = '0; act_d = '0; w_data = '0;
        for (int i = 0; i < 256; i++) rom[i] = 32'h0;
        rom[0] = 32'h3F19999A; rom[1] = 32'hBE99999A;
        rom[2] = 32'h3E4CCCCD; rom[3] = 32'h40A00000;
        rom[4] = 32'hC0000000; rom[5] = 32'h3F000000;
        rom[6] = 32'h3E99999A; rom[7] = 32'h3DCCCCCD; rom[8] = 32'hBF800000;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", {x_ready, mac_en, mac_clr, y_valid, busy, done, w_addr}, '0);
        chk("rst_mac", {mac_w, mac_x}, '0);
        chk("rst_y", {y_data, y_idx}, '0);
        rst = 1'b0;

        // x_valid while idle is not taken
        x_valid = 1'b1; x_in = 32'h1234_5678;
        @(posedge clk); #1;
        chk("idle_xready", x_ready, 1'b0);
        chk("idle_busy", busy, 1'b0);
        x_valid = 1'b0;

        // pass A: ready held high, counts, spacing, latency
        x_vec[0] = 32'h3F800000; x_vec[1] = 32'h40000000;
        y_ready = 1'b1; chk_spacing = 1'b1; cnt_en = 0; cnt_clr = 0;
        push_all();
        start_pass();
        load_x();
        wait_done(300);
        chk("mac_en_cnt", cnt_en, NN * NPAIR);
        chk("mac_clr_cnt", cnt_clr, NN);
        chk("sb_drained_a", exp_q.size(), 0);
        @(posedge clk); #1;
        chk("done_width", done, 1'b0);
        chk_spacing = 1'b0;

        // pass B: downstream stalls 10 cycles on the first result
        x_vec[0] = 32'h40400000; x_vec[1] = 32'hBF000000;
        y_ready = 1'b0;
        push_all();
        start_pass();
        load_x();
        t = 0;
        while (!y_valid && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("valid_to", y_valid, 1'b1);
        hold_data = y_data; hold_idx = y_idx;
        stall_win = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        stall_win = 1'b0;
        chk("stall_valid", y_valid, 1'b1);
        y_ready = 1'b1;
        wait_done(300);
        chk("sb_drained_b", exp_q.size(), 0);

        // pass C: reset during ISSUE of neuron 1 aborts without done
        x_vec[0] = 32'h3F800000; x_vec[1] = 32'h40000000;
        push_all();
        start_pass();
        load_x();
        t = 0;
        while (w_addr != AW'(N_IN) && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("abort_reach", w_addr, AW'(N_IN));
        done_before = n_done;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_ctrl", {x_ready, mac_en, mac_clr, y_valid, busy, done, w_addr}, '0);
        chk("abort_mac", {mac_w, mac_x}, '0);
        chk("abort_y", {y_data, y_idx}, '0);
        rst = 1'b0;
        exp_q.delete();
        repeat (5) @(posedge clk);
        #1;
        chk("abort_nodone", n_done, done_before);
        chk("abort_idle", busy, 1'b0);

        // pass D: fresh pass after abort completes normally
        x_vec[0] = 32'h3E800000; x_vec[1] = 32'h41200000;
        push_all();
        start_pass();
        load_x();
        wait_done(300);
        chk("sb_drained_d", exp_q.size(), 0);

        // pass E: start and x_valid noise while busy; results must match pass A
        x_vec[0] = 32'h3F800000; x_vec[1] = 32'h40000000;
        push_all();
        start_pass();
        load_x();
        start = 1'b1; x_valid = 1'b1; x_in = 32'hDEAD_BEEF;
        wait_accepts(2, 200);
        start = 1'b0; x_valid = 1'b0;
        wait_done(300);
        chk("sb_drained_e", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("final_idle", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
